// File: rtl/ysyx_22040931_rf_wb_arbiter.sv
// Write-back arbiter and register scoreboard for the 32x64 integer regfile.
// Optional feature: define YSYX_22040931_WB_BYPASS_EN to add write-cycle bypass outputs.
module ysyx_22040931_rf_wb_arbiter #(
  parameter int NREQ        = 3,
  parameter int DATA_W      = 64,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [5*NREQ-1:0]      req_addr_i,
  input  logic [DATA_W*NREQ-1:0] req_data_i,
  output logic                   rf_w_ena_o,
  output logic [4:0]             rf_w_addr_o,
  output logic [DATA_W-1:0]      rf_w_data_o,
  input  logic                   sb_set_i,
  input  logic [4:0]             sb_addr_i,
  input  logic [4:0]             rs1_addr_i,
  input  logic [4:0]             rs2_addr_i,
`ifdef YSYX_22040931_WB_BYPASS_EN
  output logic                   byp1_valid_o,
  output logic                   byp2_valid_o,
  output logic [DATA_W-1:0]      byp1_data_o,
  output logic [DATA_W-1:0]      byp2_data_o,
`endif
  output logic                   hazard1_o,
  output logic                   hazard2_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     ptr_q, ptr_d, gidx;
  logic              gany;
  logic [NREQ-1:0]   gnt;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              rf_w_ena_q;
  logic [4:0]        rf_w_addr_q;
  logic [DATA_W-1:0] rf_w_data_q;
  logic [31:0]       busy_q, busy_d;

  // Two-pass search: indices at/above the pointer first, then wrap to the ones below.
  always_comb begin
    gnt  = '0;
    gany = 1'b0;
    gidx = '0;
    if (!reset_i) begin
      for (int i = 0; i < NREQ; i++)
        if (!gany && req_valid_i[i] && (ROUND_ROBIN == 0 || i >= int'(ptr_q))) begin
          gany = 1'b1;
          gidx = PW'(i);
        end
      if (ROUND_ROBIN != 0)
        for (int i = 0; i < NREQ; i++)
          if (!gany && req_valid_i[i] && i < int'(ptr_q)) begin
            gany = 1'b1;
            gidx = PW'(i);
          end
      if (gany) gnt[gidx] = 1'b1;
    end
  end

  assign sel_addr    = req_addr_i[5*gidx +: 5];
  assign sel_data    = req_data_i[DATA_W*gidx +: DATA_W];
  assign ptr_d       = !gany ? ptr_q : (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
  assign req_ready_o = gnt;

  // Set is applied after clear so a newer producer for the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_w_ena_q) busy_d[rf_w_addr_q] = 1'b0;
    if (sb_set_i && sb_addr_i != 5'd0) busy_d[sb_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rf_w_ena_q  <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_data_q <= '0;
      busy_q      <= '0;
      ptr_q       <= '0;
    end else begin
      // x0 grants are consumed but never reach the regfile
      rf_w_ena_q <= gany && (sel_addr != 5'd0);
      if (gany) begin
        rf_w_addr_q <= sel_addr;
        rf_w_data_q <= sel_data;
      end
      busy_q <= busy_d;
      ptr_q  <= (ROUND_ROBIN != 0) ? ptr_d : '0;
    end
  end

  assign rf_w_ena_o  = rf_w_ena_q;
  assign rf_w_addr_o = rf_w_addr_q;
  assign rf_w_data_o = rf_w_data_q;

`ifdef YSYX_22040931_WB_BYPASS_EN
  assign byp1_valid_o = rf_w_ena_q && (rf_w_addr_q == rs1_addr_i) && (rs1_addr_i != 5'd0);
  assign byp2_valid_o = rf_w_ena_q && (rf_w_addr_q == rs2_addr_i) && (rs2_addr_i != 5'd0);
  assign byp1_data_o  = rf_w_data_q;
  assign byp2_data_o  = rf_w_data_q;
  assign hazard1_o    = busy_q[rs1_addr_i] && (rs1_addr_i != 5'd0) && !byp1_valid_o;
  assign hazard2_o    = busy_q[rs2_addr_i] && (rs2_addr_i != 5'd0) && !byp2_valid_o;
`else
  assign hazard1_o    = busy_q[rs1_addr_i] && (rs1_addr_i != 5'd0);
  assign hazard2_o    = busy_q[rs2_addr_i] && (rs2_addr_i != 5'd0);
`endif

endmodule

// File: tb/tb_ysyx_22040931_rf_wb_arbiter.sv
// Randomized + directed bench for the write-back arbiter, checked against a queue-free reference model.
module tb_ysyx_22040931_rf_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    vld, rdy, rdy_f;
  logic [5*N-1:0]  addr;
  logic [DW*N-1:0] data;
  logic            sb_set;
  logic [4:0]      sb_addr, rs1, rs2;
  logic            ena, ena_f, h1, h2, h1_f, h2_f;
  logic [4:0]      waddr, waddr_f;
  logic [DW-1:0]   wdata, wdata_f;
`ifdef YSYX_22040931_WB_BYPASS_EN
  logic            bv1, bv2, bv1_f, bv2_f;
  logic [DW-1:0]   bd1, bd2, bd1_f, bd2_f;
`endif

  always #5 clk = ~clk;

  ysyx_22040931_rf_wb_arbiter #(.NREQ(N), .DATA_W(DW), .ROUND_ROBIN(1)) dut (
    .clock_i(clk), .reset_i(rst), .req_valid_i(vld), .req_ready_o(rdy),
    .req_addr_i(addr), .req_data_i(data), .rf_w_ena_o(ena), .rf_w_addr_o(waddr),
    .rf_w_data_o(wdata), .sb_set_i(sb_set), .sb_addr_i(sb_addr),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2),
`ifdef YSYX_22040931_WB_BYPASS_EN
    .byp1_valid_o(bv1), .byp2_valid_o(bv2), .byp1_data_o(bd1), .byp2_data_o(bd2),
`endif
    .hazard1_o(h1), .hazard2_o(h2));

  ysyx_22040931_rf_wb_arbiter #(.NREQ(N), .DATA_W(DW), .ROUND_ROBIN(0)) dut_f (
    .clock_i(clk), .reset_i(rst), .req_valid_i(vld), .req_ready_o(rdy_f),
    .req_addr_i(addr), .req_data_i(data), .rf_w_ena_o(ena_f), .rf_w_addr_o(waddr_f),
    .rf_w_data_o(wdata_f), .sb_set_i(sb_set), .sb_addr_i(sb_addr),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2),
`ifdef YSYX_22040931_WB_BYPASS_EN
    .byp1_valid_o(bv1_f), .byp2_valid_o(bv2_f), .byp1_data_o(bd1_f), .byp2_data_o(bd2_f),
`endif
    .hazard1_o(h1_f), .hazard2_o(h2_f));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // reference model of the round-robin instance
  bit            busy_m[32];
  int            ptr_m = 0;
  bit            ena_m = 0;
  logic [4:0]    waddr_m = '0;
  logic [DW-1:0] wdata_m = '0;

  function automatic logic [4:0] src_addr(input int i);
    return addr[5*i +: 5];
  endfunction

  function automatic bit exp_haz(input logic [4:0] rs);
    bit h;
    h = (rs != 0) && busy_m[rs];
`ifdef YSYX_22040931_WB_BYPASS_EN
    if (ena_m && waddr_m == rs) h = 0;
`endif
    return h;
  endfunction

  // Called #0 after a negedge input change: checks the cycle, then advances the model.
  task automatic eval();
    int g, gf, idx;
    #1;
    g = -1; gf = -1;
    if (!rst)
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (g < 0 && vld[idx]) g = idx;
        if (gf < 0 && vld[k]) gf = k;
      end
    chk("ready_rr", 64'(rdy), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("ready_fp", 64'(rdy_f), (gf < 0) ? 64'd0 : (64'd1 << gf));
    chk("w_ena", 64'(ena), 64'(ena_m));
    if (ena_m) begin
      chk("w_addr", 64'(waddr), 64'(waddr_m));
      chk("w_data", wdata, wdata_m);
    end
    chk("hazard1", 64'(h1), 64'(exp_haz(rs1)));
    chk("hazard2", 64'(h2), 64'(exp_haz(rs2)));
`ifdef YSYX_22040931_WB_BYPASS_EN
    chk("byp1_v", 64'(bv1), 64'(ena_m && waddr_m == rs1 && rs1 != 0));
    chk("byp2_v", 64'(bv2), 64'(ena_m && waddr_m == rs2 && rs2 != 0));
    if (bv1) chk("byp1_d", bd1, wdata_m);
`endif
    if (rst) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      ptr_m = 0; ena_m = 0; waddr_m = '0; wdata_m = '0;
    end else begin
      if (ena_m) busy_m[waddr_m] = 0;
      if (sb_set && sb_addr != 0) busy_m[sb_addr] = 1;
      if (g >= 0) begin
        ena_m   = (src_addr(g) != 0);
        waddr_m = src_addr(g);
        wdata_m = data[DW*g +: DW];
        ptr_m   = (g + 1) % N;
      end else ena_m = 0;
    end
  endtask

  task automatic idle();
    vld = '0; sb_set = 0; sb_addr = '0;
  endtask

  initial begin
    logic [N-1:0] rr_exp [4];
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    rst = 1; idle(); addr = '0; data = '0; rs1 = '0; rs2 = '0;
    foreach (busy_m[i]) busy_m[i] = 0;
    @(negedge clk);

    // reset with all requesters valid
    repeat (2) begin
      @(negedge clk); rst = 1; vld = '1; addr = {5'd3, 5'd2, 5'd1}; rs1 = 5'd3; rs2 = 5'd4;
      eval();
      chk("rst_ready", 64'(rdy), 64'd0);
      chk("rst_ena", 64'(ena), 64'd0);
      chk("rst_addr", 64'(waddr), 64'd0);
      chk("rst_data", wdata, 64'd0);
      chk("rst_haz", 64'({h1, h2}), 64'd0);
    end
    @(negedge clk); rst = 0; idle(); eval();

    // single write from src1
    @(negedge clk); vld = 3'b010; addr[9:5] = 5'd5; data[127:64] = 64'hDEAD; eval();
    chk("single_ready", 64'(rdy), 64'b010);
    @(negedge clk); idle(); eval();
    chk("single_ena", 64'(ena), 64'd1);
    chk("single_addr", 64'(waddr), 64'd5);
    chk("single_data", wdata, 64'hDEAD);

    // round-robin vs fixed priority from a freshly reset pointer
    @(negedge clk); rst = 1; eval();
    @(negedge clk); rst = 0; eval();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); vld = 3'b111; addr = {5'd3, 5'd2, 5'd1}; eval();
      chk("rr_seq", 64'(rdy), 64'(rr_exp[c]));
      chk("fp_seq", 64'(rdy_f), 64'b001);
    end

    // scoreboard on x7
    @(negedge clk); idle(); sb_set = 1; sb_addr = 5'd7; eval();
    @(negedge clk); idle(); rs1 = 5'd7; rs2 = 5'd0; eval();
    chk("sb7_busy", 64'(h1), 64'd1);
    @(negedge clk); vld = 3'b001; addr[4:0] = 5'd7; data[63:0] = 64'h77; eval();
    chk("sb7_grant_cyc", 64'(h1), 64'd1);
    @(negedge clk); idle(); eval();
`ifdef YSYX_22040931_WB_BYPASS_EN
    chk("sb7_wr_cyc", 64'(h1), 64'd0);
    chk("sb7_byp_data", bd1, 64'h77);
`else
    chk("sb7_wr_cyc", 64'(h1), 64'd1);
`endif
    @(negedge clk); eval();
    chk("sb7_clear", 64'(h1), 64'd0);

    // set and clear of x9 on the same edge
    @(negedge clk); idle(); sb_set = 1; sb_addr = 5'd9; eval();
    @(negedge clk); idle(); vld = 3'b001; addr[4:0] = 5'd9; eval();
    @(negedge clk); idle(); sb_set = 1; sb_addr = 5'd9; eval();
    chk("col_ena", 64'(ena), 64'd1);
    @(negedge clk); idle(); rs1 = 5'd9; eval();
    chk("col_haz", 64'(h1), 64'd1);
    @(negedge clk); eval();
    chk("col_haz2", 64'(h1), 64'd1);

    // x0 handling
    @(negedge clk); idle(); vld = 3'b100; addr[14:10] = 5'd0; eval();
    chk("x0_ready", 64'(rdy), 64'b100);
    @(negedge clk); idle(); eval();
    chk("x0_ena", 64'(ena), 64'd0);
    @(negedge clk); sb_set = 1; sb_addr = 5'd0; rs1 = 5'd0; eval();
    @(negedge clk); idle(); eval();
    chk("x0_haz", 64'(h1), 64'd0);

    // random traffic on a small register window to force collisions
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 59) == 0);
      vld     = N'($urandom);
      for (int i = 0; i < N; i++) begin
        addr[5*i +: 5]  = 5'($urandom_range(0, 7));
        data[DW*i +: DW] = {$urandom, $urandom};
      end
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = 5'($urandom_range(0, 7));
      rs1     = 5'($urandom_range(0, 7));
      rs2     = 5'($urandom_range(0, 7));
      eval();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
